// File: rtl/fifo_ctrl_2p256d36.sv
// FWFT FIFO controller for an external 256x36 two-port RAM with a 2-entry output skid buffer.
// Optional registered almostFull flag: define FIFO_CTRL_ALMOST_FULL_EN.
module fifo_ctrl_2p256d36 #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 36,
  parameter int AFULL_LEVEL = 240
) (
  input  logic              clockCore,
  input  logic              resetCoreN,
  input  logic              flush,
  input  logic              pushValid,
  output logic              pushReady,
  input  logic [DATA_W-1:0] pushData,
  output logic              popValid,
  input  logic              popReady,
  output logic [DATA_W-1:0] popData,
  output logic              almostFull,
  output logic [ADDR_W+1:0] usedWords,
  output logic              ramEnableWrite,
  output logic [ADDR_W-1:0] ramAddressWrite,
  output logic [DATA_W-1:0] ramWriteData,
  output logic              ramEnableRead,
  output logic [ADDR_W-1:0] ramAddressRead,
  input  logic [DATA_W-1:0] ramReadData
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_count_q, mem_count_d;
  logic              in_flight_q, in_flight_d;
  logic [1:0]        buf_count_q, buf_count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  logic       push_fire;
  logic       pop_fire;
  logic       read_issue;
  logic       capture;
  logic [2:0] buf_occ;

  assign pushReady = (mem_count_q != DEPTH_C);
  assign popValid  = (buf_count_q != 2'd0);
  assign popData   = head_q;
  assign push_fire = pushValid && pushReady && !flush;
  assign pop_fire  = popValid && popReady && !flush;

  // Occupancy of the skid buffer once the outstanding read lands; a pop this cycle frees a slot.
  assign buf_occ    = {1'b0, buf_count_q} + {2'b00, in_flight_q} - {2'b00, pop_fire};
  assign read_issue = (mem_count_q != '0) && (buf_occ < 3'd2) && !flush;
  assign capture    = in_flight_q && !flush;

  assign ramEnableWrite  = push_fire;
  assign ramAddressWrite = wr_ptr_q;
  assign ramWriteData    = pushData;
  assign ramEnableRead   = read_issue;
  assign ramAddressRead  = rd_ptr_q;

  assign usedWords = {1'b0, mem_count_q} + {{(ADDR_W+1){1'b0}}, in_flight_q}
                   + {{ADDR_W{1'b0}}, buf_count_q};

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{(ADDR_W-1){1'b0}}, push_fire};
    rd_ptr_d    = rd_ptr_q + {{(ADDR_W-1){1'b0}}, read_issue};
    in_flight_d = read_issue;
    mem_count_d = mem_count_q;
    case ({push_fire, read_issue})
      2'b10:   mem_count_d = mem_count_q + 1'b1;
      2'b01:   mem_count_d = mem_count_q - 1'b1;
      default: mem_count_d = mem_count_q;
    endcase
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
    end
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    buf_count_d = buf_count_q;
    if (flush) begin
      buf_count_d = 2'd0;
    end else begin
      case ({capture, pop_fire})
        2'b10: begin
          if (buf_count_q == 2'd0) head_d = ramReadData;
          else                     tail_d = ramReadData;
          buf_count_d = buf_count_q + 2'd1;
        end
        2'b01: begin
          head_d      = tail_q;
          buf_count_d = buf_count_q - 2'd1;
        end
        2'b11: begin
          // Count stays; the landing word goes behind whatever remains after the pop.
          if (buf_count_q == 2'd1) begin
            head_d = ramReadData;
          end else begin
            head_d = tail_q;
            tail_d = ramReadData;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      in_flight_q <= 1'b0;
      buf_count_q <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      in_flight_q <= in_flight_d;
      buf_count_q <= buf_count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

`ifdef FIFO_CTRL_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AFULL_C = AFULL_LEVEL[ADDR_W:0];
  logic almost_full_q;

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) almost_full_q <= 1'b0;
    else             almost_full_q <= (mem_count_d >= AFULL_C);
  end

  assign almostFull = almost_full_q;
`else
  assign almostFull = 1'b0;
`endif

endmodule
